// File: rtl/lockin_reference_generator.sv
`default_nettype none
// ============================================================================
//  Module   : lockin_reference_generator
//  Purpose  : Quadrature NCO reference for a lock-in amplifier. It has a phase
//             accumulator, a quarter-wave sine table and a 4-stage pipeline.
//  Options  : define NCO_COS_EN to build the cosine path (cos_o is 0 otherwise)
//  Revision : 1.0 - initial release
// ============================================================================
module lockin_reference_generator #(
    parameter int NUM_BITS      = 24,
    parameter int PHASE_BITS    = 32,
    parameter int LUT_ADDR_BITS = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  tick_i,
    input  logic [PHASE_BITS-1:0] freq_word_i,
    input  logic                  freq_load_i,
    input  logic [PHASE_BITS-1:0] phase_offset_i,
    input  logic [NUM_BITS-2:0]   amplitude_i,
    output logic [NUM_BITS-1:0]   sin_o,
    output logic [NUM_BITS-1:0]   cos_o,
    output logic                  valid_o,
    output logic                  wrap_o
);

    localparam int LUT_W     = NUM_BITS - 1;
    localparam int LUT_DEPTH = 2 ** LUT_ADDR_BITS;
    localparam int TOP_W     = LUT_ADDR_BITS + 2;
    localparam int PH_SHIFT  = PHASE_BITS - TOP_W;
    localparam int PROD_W    = 2 * NUM_BITS;
    localparam logic [127:0] C_HALF_PI = 128'h1921FB54442D1846;  // pi/2 in Q60
    localparam logic [127:0] C_LUT_MAX = (128'd1 << LUT_W) - 128'd1;
    localparam logic [127:0] C_ROUND   = 128'd1 << 59;

    // Taylor series in Q60 fixed point. This is evaluated only when the table is elaborated.
    function automatic logic [LUT_W-1:0] lut_entry(input int idx);
        logic [127:0] x, x2, term, sum, scaled;
        x    = (C_HALF_PI * 128'(2 * idx + 1)) >> (LUT_ADDR_BITS + 1);
        x2   = (x * x) >> 60;
        term = x;
        sum  = x;
        for (int k = 1; k <= 8; k++) begin
            term = ((term * x2) >> 60) / 128'((2 * k) * (2 * k + 1));
            if (k % 2 == 1) sum = sum - term;
            else            sum = sum + term;
        end
        scaled = (sum * C_LUT_MAX + C_ROUND) >> 60;
        return LUT_W'(scaled);
    endfunction

    function automatic logic [NUM_BITS-1:0] scale_sample(input logic [LUT_W-1:0] mag,
                                                         input logic             neg,
                                                         input logic [LUT_W-1:0] amp);
        logic signed [NUM_BITS-1:0] smp;
        logic signed [PROD_W-1:0]   prod;
        smp = {1'b0, mag};
        if (neg) smp = -smp;
        prod = $signed({{NUM_BITS{smp[NUM_BITS-1]}}, smp} * {{(NUM_BITS + 1){1'b0}}, amp});
        return NUM_BITS'(prod >>> (NUM_BITS - 1));
    endfunction

    logic [LUT_W-1:0] w_rom [LUT_DEPTH];
    for (genvar gi = 0; gi < LUT_DEPTH; gi++) begin : g_rom
        localparam logic [LUT_W-1:0] C_ENTRY = lut_entry(gi);
        assign w_rom[gi] = C_ENTRY;
    end

    // Stage 1: accumulate
    logic [PHASE_BITS-1:0]    acc_q, freq_q, w_freq_eff;
    logic [PHASE_BITS:0]      w_acc_sum;
    logic [TOP_W-1:0]         ph1_q, ph1_d;
    logic                     carry_q, v1_q, wrap1_q;
    logic [LUT_W-1:0]         amp1_q, amp2_q, amp3_q;
    // Stage 2: decode; stage 3: table register
    logic [1:0]               w_quad;
    logic [LUT_ADDR_BITS-1:0] w_addr, sin_addr2_q;
    logic                     sin_neg2_q, sin_neg3_q, v2_q, v3_q, wrap2_q, wrap3_q;
    logic [LUT_W-1:0]         sin_lut3_q;

    always_comb begin
        w_freq_eff = freq_load_i ? freq_word_i : freq_q;
        w_acc_sum  = {1'b0, acc_q} + {1'b0, w_freq_eff};
        ph1_d      = TOP_W'((acc_q + phase_offset_i) >> PH_SHIFT);
        w_quad     = ph1_q[TOP_W-1 -: 2];
        w_addr     = ph1_q[LUT_ADDR_BITS-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            acc_q       <= '0;
            freq_q      <= '0;
            carry_q     <= 1'b0;
            ph1_q       <= '0;
            amp1_q      <= '0;
            amp2_q      <= '0;
            amp3_q      <= '0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
            wrap1_q     <= 1'b0;
            wrap2_q     <= 1'b0;
            wrap3_q     <= 1'b0;
            sin_addr2_q <= '0;
            sin_neg2_q  <= 1'b0;
            sin_neg3_q  <= 1'b0;
            sin_lut3_q  <= '0;
            sin_o       <= '0;
            valid_o     <= 1'b0;
            wrap_o      <= 1'b0;
        end else begin
            if (freq_load_i) freq_q <= freq_word_i;
            // The carry from the previous increment marks the next sample as the period start.
            v1_q    <= tick_i;
            wrap1_q <= tick_i & carry_q;
            if (tick_i) begin
                acc_q   <= w_acc_sum[PHASE_BITS-1:0];
                carry_q <= w_acc_sum[PHASE_BITS];
                ph1_q   <= ph1_d;
                amp1_q  <= amplitude_i;
            end

            v2_q        <= v1_q;
            wrap2_q     <= wrap1_q;
            amp2_q      <= amp1_q;
            sin_addr2_q <= w_quad[0] ? ~w_addr : w_addr;
            sin_neg2_q  <= w_quad[1];

            v3_q        <= v2_q;
            wrap3_q     <= wrap2_q;
            amp3_q      <= amp2_q;
            sin_lut3_q  <= w_rom[sin_addr2_q];
            sin_neg3_q  <= sin_neg2_q;

            valid_o <= v3_q;
            wrap_o  <= v3_q & wrap3_q;
            if (v3_q) sin_o <= scale_sample(sin_lut3_q, sin_neg3_q, amp3_q);
        end
    end

`ifdef NCO_COS_EN
    // Cosine is the same phase advanced by a quarter turn, which means quadrant + 1.
    logic [1:0]               w_cquad;
    logic [LUT_ADDR_BITS-1:0] cos_addr2_q;
    logic                     cos_neg2_q, cos_neg3_q;
    logic [LUT_W-1:0]         cos_lut3_q;

    always_comb begin
        w_cquad = w_quad + 2'd1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cos_addr2_q <= '0;
            cos_neg2_q  <= 1'b0;
            cos_neg3_q  <= 1'b0;
            cos_lut3_q  <= '0;
            cos_o       <= '0;
        end else begin
            cos_addr2_q <= w_cquad[0] ? ~w_addr : w_addr;
            cos_neg2_q  <= w_cquad[1];
            cos_lut3_q  <= w_rom[cos_addr2_q];
            cos_neg3_q  <= cos_neg2_q;
            if (v3_q) cos_o <= scale_sample(cos_lut3_q, cos_neg3_q, amp3_q);
        end
    end
`else
    assign cos_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lockin_reference_generator.sv
`default_nettype none
// Directed self-checking bench for lockin_reference_generator (default widths).
module tb_lockin_reference_generator;

    localparam int NUM_BITS = 24;
`ifdef NCO_COS_EN
    localparam bit COS_EN = 1'b1;
`else
    localparam bit COS_EN = 1'b0;
`endif
    localparam logic [22:0] AMP_FULL = 23'd8388607;
    localparam logic [22:0] AMP_HALF = 23'd4194304;

    logic                clk_i = 1'b0;
    logic                reset_i = 1'b0;
    logic                tick_i = 1'b0;
    logic [31:0]         freq_word_i = '0;
    logic                freq_load_i = 1'b0;
    logic [31:0]         phase_offset_i = '0;
    logic [22:0]         amplitude_i = '0;
    logic [NUM_BITS-1:0] sin_o, cos_o;
    logic                valid_o, wrap_o;

    int checks = 0;
    int errors = 0;

    lockin_reference_generator #(
        .NUM_BITS      (24),
        .PHASE_BITS    (32),
        .LUT_ADDR_BITS (8)
    ) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .tick_i         (tick_i),
        .freq_word_i    (freq_word_i),
        .freq_load_i    (freq_load_i),
        .phase_offset_i (phase_offset_i),
        .amplitude_i    (amplitude_i),
        .sin_o          (sin_o),
        .cos_o          (cos_o),
        .valid_o        (valid_o),
        .wrap_o         (wrap_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] sx(input logic [NUM_BITS-1:0] v);
        return 32'($signed(v));
    endfunction

    function automatic logic [31:0] cx(input int v);
        return COS_EN ? 32'(v) : 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        step();
        step();
        reset_i = 1'b0;
    endtask

    // n back-to-back ticks; each sample is expected exactly 4 cycles after its tick.
    task automatic burst(input string tag, input int n, input bit do_load, input logic [31:0] word,
                         input int es[8], input int ec[8], input int ew[8]);
        for (int i = 0; i < n + 3; i++) begin
            tick_i = (i < n);
            if (i == 0) begin
                freq_load_i = do_load;
                freq_word_i = word;
            end else begin
                freq_load_i = 1'b0;
            end
            step();
            if (i >= 3) begin
                chk({tag, "_valid"}, 32'(valid_o), 32'd1);
                chk({tag, "_sin"}, sx(sin_o), 32'(es[i-3]));
                chk({tag, "_cos"}, sx(cos_o), cx(ec[i-3]));
                chk({tag, "_wrap"}, 32'(wrap_o), 32'(ew[i-3]));
            end else begin
                chk({tag, "_early_valid"}, 32'(valid_o), 32'd0);
            end
        end
        tick_i = 1'b0;
        step();
        chk({tag, "_after_valid"}, 32'(valid_o), 32'd0);
        chk({tag, "_hold_sin"}, sx(sin_o), 32'(es[n-1]));
    endtask

    initial begin
        int es[8];
        int ec[8];
        int ew[8];

        // Reset state
        do_reset();
        chk("rst_sin", sx(sin_o), 32'd0);
        chk("rst_cos", sx(cos_o), 32'd0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_wrap", 32'(wrap_o), 32'd0);

        // Single tick, freq 0, full amplitude
        amplitude_i = AMP_FULL;
        es = '{25735, 0, 0, 0, 0, 0, 0, 0};
        ec = '{8388567, 0, 0, 0, 0, 0, 0, 0};
        ew = '{0, 0, 0, 0, 0, 0, 0, 0};
        burst("single", 1, 1'b1, 32'd0, es, ec, ew);

        // Quarter-turn steps with wrap on the fifth sample
        do_reset();
        freq_load_i = 1'b1;
        freq_word_i = 32'h4000_0000;
        step();
        freq_load_i = 1'b0;
        freq_word_i = 32'd0;
        es = '{25735, 8388567, -25736, -8388568, 25735, 0, 0, 0};
        ec = '{8388567, -25736, -8388568, 25735, 8388567, 0, 0, 0};
        ew = '{0, 0, 0, 0, 1, 0, 0, 0};
        burst("quarter", 5, 1'b0, 32'd0, es, ec, ew);

        // Zero amplitude
        do_reset();
        amplitude_i = 23'd0;
        es = '{0, 0, 0, 0, 0, 0, 0, 0};
        ec = '{0, 0, 0, 0, 0, 0, 0, 0};
        ew = '{0, 0, 0, 0, 0, 0, 0, 0};
        burst("zeroamp", 3, 1'b1, 32'h1234_5678, es, ec, ew);

        // Frequency load coincident with the first tick
        do_reset();
        amplitude_i = AMP_FULL;
        es = '{25735, -25736, 0, 0, 0, 0, 0, 0};
        ec = '{8388567, -8388568, 0, 0, 0, 0, 0, 0};
        ew = '{0, 0, 0, 0, 0, 0, 0, 0};
        burst("loadtick", 2, 1'b1, 32'h8000_0000, es, ec, ew);

        // Reset two cycles after a tick kills the in-flight sample
        tick_i = 1'b1;
        step();
        tick_i = 1'b0;
        step();
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        chk("midrst_valid_n3", 32'(valid_o), 32'd0);
        step();
        chk("midrst_valid_n4", 32'(valid_o), 32'd0);
        chk("midrst_sin", sx(sin_o), 32'd0);
        chk("midrst_cos", sx(cos_o), 32'd0);
        chk("midrst_wrap", 32'(wrap_o), 32'd0);
        step();
        chk("midrst_valid_n5", 32'(valid_o), 32'd0);

        // Half-turn phase offset
        phase_offset_i = 32'h8000_0000;
        es = '{-25736, 0, 0, 0, 0, 0, 0, 0};
        ec = '{-8388568, 0, 0, 0, 0, 0, 0, 0};
        ew = '{0, 0, 0, 0, 0, 0, 0, 0};
        burst("offset", 1, 1'b0, 32'd0, es, ec, ew);

        // Half amplitude at both signs
        amplitude_i    = AMP_HALF;
        phase_offset_i = 32'd0;
        es = '{12868, 12868, 0, 0, 0, 0, 0, 0};
        ec = '{4194284, 4194284, 0, 0, 0, 0, 0, 0};
        burst("halfamp", 2, 1'b0, 32'd0, es, ec, ew);
        phase_offset_i = 32'h8000_0000;
        es = '{-12868, 0, 0, 0, 0, 0, 0, 0};
        ec = '{-4194284, 0, 0, 0, 0, 0, 0, 0};
        burst("halfneg", 1, 1'b0, 32'd0, es, ec, ew);

        // Amplitude and offset are captured in the tick cycle only
        amplitude_i    = AMP_FULL;
        phase_offset_i = 32'd0;
        tick_i = 1'b1;
        step();
        tick_i         = 1'b0;
        amplitude_i    = 23'd0;
        phase_offset_i = 32'h8000_0000;
        step();
        step();
        step();
        chk("capture_valid", 32'(valid_o), 32'd1);
        chk("capture_sin", sx(sin_o), 32'd25735);
        chk("capture_cos", sx(cos_o), cx(8388567));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lockin_reference_generator.md
LOCKIN_REFERENCE_GENERATOR -- requirements
Module: lockin_reference_generator

Interface
REQ-001 SHALL have parameter NUM_BITS, default 24, meaning output sample width (signed).
REQ-002 SHALL have parameter PHASE_BITS, default 32, meaning phase accumulator width.
REQ-003 SHALL have parameter LUT_ADDR_BITS, default 8, meaning quarter-wave table address width (256 entries).
REQ-004 SHALL have clk_i, input, 1, meaning the single clock; all logic on its rising edge.
REQ-005 SHALL have reset_i, input, 1, meaning synchronous active-high reset.
REQ-006 SHALL have tick_i, input, 1, meaning sample strobe; one output sample per high cycle; may be high every cycle.
REQ-007 SHALL have freq_word_i, input, PHASE_BITS, meaning unsigned phase increment per tick.
REQ-008 SHALL have freq_load_i, input, 1, meaning single-cycle pulse that latches freq_word_i.
REQ-009 SHALL have phase_offset_i, input, PHASE_BITS, meaning unsigned offset added to the accumulator before lookup.
REQ-010 SHALL have amplitude_i, input, NUM_BITS-1, meaning unsigned Q0.23 gain, where 8388607 is approximately unity.
REQ-011 SHALL have sin_o, output, NUM_BITS, meaning signed sine reference sample.
REQ-012 SHALL have cos_o, output, NUM_BITS, meaning signed cosine (quadrature) reference sample.
REQ-013 SHALL have valid_o, output, 1, meaning one-cycle pulse marking new sin_o/cos_o.
REQ-014 SHALL have wrap_o, output, 1, meaning high with valid_o on the first sample of a new reference period.

Function
REQ-015 SHALL keep a pending frequency register; freq_load_i high loads it with freq_word_i; if freq_load_i and tick_i coincide, that tick SHALL use the new word.
REQ-016 SHALL, on each tick, sample phase p = acc + phase_offset_i (mod 2^PHASE_BITS) using acc before increment, then update acc <= acc + freq (mod 2^PHASE_BITS).
REQ-017 SHALL record the carry of each increment; wrap_o SHALL accompany the next tick's sample; no wrap_o on the first tick after reset.
REQ-018 SHALL decode quadrant q = p[31:30] and address a = p[29:22]; sample = LUT[a], LUT[255-a], -LUT[a], -LUT[255-a] for q = 0, 1, 2, 3.
REQ-019 SHALL fill LUT[a] = round(8388607*sin(pi/2*(a+0.5)/256)); negation never overflows.
REQ-020 SHALL form the cosine phase as p + 2^30 through an identical path.
REQ-021 SHALL scale via a 48-bit signed product of sample * {0,amplitude_i}, output bits [46:23] (floor; arithmetic shift), with no saturation needed.
REQ-022 SHALL be a fully pipelined 4-stage path (accumulate, decode, LUT register, sign/scale); valid_o SHALL be high exactly 4 cycles after the tick_i cycle.
REQ-023 SHALL hold sin_o/cos_o between valid pulses.
REQ-024 SHALL sample amplitude_i and phase_offset_i in the tick cycle.

Reset
REQ-025 SHALL, on reset_i, clear acc, the pending frequency, the carry flag, all pipeline valids, sin_o, cos_o, valid_o and wrap_o to 0.
REQ-026 SHALL discard in-flight samples on reset mid-pipeline, with no valid_o generated for them.

Configuration
REQ-027 SHALL, with NCO_COS_EN defined, implement the cosine path of REQ-020.
REQ-028 SHALL, without NCO_COS_EN, remove the cosine path and tie cos_o to 0; sin_o timing SHALL be unchanged.

Verification
REQ-029 SHALL check: reset, load freq 0, amplitude 8388607, one tick -> 4 cycles later valid_o=1, sin_o=25735, cos_o=8388567, wrap_o=0.
REQ-030 SHALL check: freq 2^30 loaded, 5 ticks -> sin_o 25735, 8388567, -25736, -8388568, 25735; wrap_o=1 only on the 5th.
REQ-031 SHALL check: amplitude 0, any freq, ticks -> valid_o pulses, sin_o=cos_o=0.
REQ-032 SHALL check: acc=0 with freq 0 pending, freq_load_i with freq_word_i=2^31 in the same cycle as tick -> 1st sample 25735, 2nd sample -25736.
REQ-033 SHALL check: tick at cycle N, reset_i at N+2 -> no valid_o at N+4, outputs 0.
REQ-034 SHALL check: freq 0, phase_offset_i=2^31 -> sin_o=-25736, cos_o=-8388568; without NCO_COS_EN, cos_o=0.
